bcd_updown_counter: RTL and testbench

Parametrised successor to the single-digit 0–5 display counter. It is a multi-digit BCD up/down counter with a configurable modulus, an internal tick divider and registered seven-segment outputs for every digit. It sits between the board clock/switches and the seven-segment displays, and replaces the fixed divider, state machine and decoder chain with one configurable block.

---
 rtl/seg_counter_pkg.sv | 42 ++++
 rtl/bcd_digit_step.sv | 41 ++++
 rtl/bcd_updown_counter.sv | 144 ++++++++++++++
 tb/tb_bcd_updown_counter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seg_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_counter_pkg
// Description : Shared seven-segment patterns (active-low, gfedcba) and the
//               BCD-digit-to-segment encoder used by the display counter.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_counter_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Non-BCD nibbles cannot occur in the counter; they map to blank anyway.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_step.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_step
// Description : One BCD digit of an up/down ripple counter. With carry_in
//               set the digit steps by one in the chosen direction; a 9->0
//               (up) or 0->9 (down) roll produces carry_out for the next digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_step (
  input  logic [3:0] digit,
  input  logic       up,
  input  logic       carry_in,
  output logic [3:0] next_digit,
  output logic       carry_out
);

  // Per-digit increment/decrement with roll-over carry/borrow.
  always_comb begin
    next_digit = digit;
    carry_out  = 1'b0;
    if (carry_in) begin
      if (up) begin
        if (digit >= 4'd9) begin
          next_digit = 4'd0;
          carry_out  = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
        end
      end else begin
        if (digit == 4'd0) begin
          next_digit = 4'd9;
          carry_out  = 1'b1;
        end else begin
          next_digit = digit - 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_updown_counter
// Description : Multi-digit BCD up/down counter with modulus MAX_VALUE+1,
//               internal step divider and registered seven-segment outputs.
//               Optional macro SEG_LEADING_BLANK_EN blanks leading zero
//               digits above digit 0 on the display (Value is unaffected).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_updown_counter
  import seg_counter_pkg::*;
#(
  parameter int DIV_COUNT = 25000000,
  parameter int DIGITS    = 2,
  parameter int MAX_VALUE = 59
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  In,
  input  logic                  Enable,
  input  logic                  Clear,
  output logic [4*DIGITS-1:0]   Value,
  output logic [7*DIGITS-1:0]   Out,
  output logic                  Tick,
  output logic                  Wrap
);

  localparam int              DIV_W    = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);

  // Binary-to-BCD conversion of the modulus limit, evaluated at elaboration.
  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] b;
    int                  r;
    b = '0;
    r = v;
    for (int k = 0; k < DIGITS; k++) begin
      b[4*k +: 4] = 4'(r % 10);
      r           = r / 10;
    end
    return b;
  endfunction

  localparam logic [4*DIGITS-1:0] MAX_BCD = to_bcd(MAX_VALUE);

  // Segment image of a whole BCD value, with optional leading-zero blanking.
  function automatic logic [7*DIGITS-1:0] encode_display(input logic [4*DIGITS-1:0] v);
    logic [7*DIGITS-1:0] seg;
`ifdef SEG_LEADING_BLANK_EN
    logic                zero_above;
    zero_above = 1'b1;
`endif
    seg = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      seg[7*k +: 7] = seg_encode(v[4*k +: 4]);
`ifdef SEG_LEADING_BLANK_EN
      zero_above = zero_above & (v[4*k +: 4] == 4'd0);
      if ((k != 0) && zero_above) begin
        seg[7*k +: 7] = SEG_BLANK;
      end
`endif
    end
    return seg;
  endfunction

  logic [DIV_W-1:0]    div_q,   div_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [7*DIGITS-1:0] out_q,   out_d;
  logic                wrap_q,  wrap_d;

  logic                step_up;
  logic                wrap_cond;
  logic [4*DIGITS-1:0] stepped;
  logic [DIGITS-1:0]   carry_out;

  assign step_up = ~In;
  assign Tick    = Enable & (div_q == DIV_LAST);

  // Ripple chain: digit 0 always steps, higher digits step on carry/borrow.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic cin;
    if (k == 0) begin : g_first
      assign cin = 1'b1;
    end else begin : g_rest
      assign cin = carry_out[k-1];
    end
    bcd_digit_step u_step (
      .digit      (value_q[4*k +: 4]),
      .up         (step_up),
      .carry_in   (cin),
      .next_digit (stepped[4*k +: 4]),
      .carry_out  (carry_out[k])
    );
  end

  // Going down, a borrow out of the top digit means the value was 0.
  assign wrap_cond = step_up ? (value_q == MAX_BCD) : carry_out[DIGITS-1];

  // Next-state: divider, count with modulus wrap, wrap pulse, display image.
  always_comb begin
    div_d   = div_q;
    value_d = value_q;
    wrap_d  = 1'b0;
    out_d   = encode_display(value_q);

    if (!Enable || Clear || (div_q == DIV_LAST)) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (Clear) begin
      value_d = '0;
    end else if (Tick) begin
      if (wrap_cond) begin
        value_d = step_up ? '0 : MAX_BCD;
        wrap_d  = 1'b1;
      end else begin
        value_d = stepped;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      div_q   <= '0;
      value_q <= '0;
      wrap_q  <= 1'b0;
      out_q   <= encode_display('0);
    end else begin
      div_q   <= div_d;
      value_q <= value_d;
      wrap_q  <= wrap_d;
      out_q   <= out_d;
    end
  end

  assign Value = value_q;
  assign Out   = out_q;
  assign Wrap  = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_updown_counter
// Description : Directed self-checking bench for bcd_updown_counter with
//               DIV_COUNT=4, DIGITS=2, MAX_VALUE=59. Honours the
//               SEG_LEADING_BLANK_EN macro for display expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_updown_counter;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] SB = 7'b1111111;
`ifdef SEG_LEADING_BLANK_EN
  localparam logic [6:0] HI_ZERO = SB;
`else
  localparam logic [6:0] HI_ZERO = S0;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  logic        In;
  logic        Enable;
  logic        Clear;
  logic [7:0]  Value;
  logic [13:0] Out;
  logic        Tick;
  logic        Wrap;

  int checks   = 0;
  int failures = 0;

  bcd_updown_counter #(
    .DIV_COUNT (4),
    .DIGITS    (2),
    .MAX_VALUE (59)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .In     (In),
    .Enable (Enable),
    .Clear  (Clear),
    .Value  (Value),
    .Out    (Out),
    .Tick   (Tick),
    .Wrap   (Wrap)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic run_edges(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset  = 1'b1;
    In     = 1'b0;
    Enable = 1'b0;
    Clear  = 1'b0;
    run_edges(2);
    check_eq("rst_value", 32'(Value), 32'h00);
    check_eq("rst_tick",  32'(Tick),  32'd0);
    check_eq("rst_wrap",  32'(Wrap),  32'd0);
    check_eq("rst_out",   32'(Out),   32'({HI_ZERO, S0}));

    // Count up from reset: tick on the 3rd edge, step on the 4th.
    Reset  = 1'b0;
    Enable = 1'b1;
    run_edges(2);
    check_eq("tick_e2",   32'(Tick),  32'd0);
    run_edges(1);
    check_eq("tick_e3",   32'(Tick),  32'd1);
    run_edges(1);
    check_eq("first_step", 32'(Value), 32'h01);
    check_eq("tick_e4",   32'(Tick),  32'd0);
    check_eq("out_lag",   32'(Out[6:0]), 32'(S0));
    run_edges(1);
    check_eq("out_d0_one", 32'(Out[6:0]), 32'(S1));
    run_edges(3);
    check_eq("second_step", 32'(Value), 32'h02);

    // Up to 58, then 59, then wrap to 00.
    repeat (56) run_edges(4);
    check_eq("up_58", 32'(Value), 32'h58);
    run_edges(4);
    check_eq("up_59", 32'(Value), 32'h59);
    check_eq("up_59_nowrap", 32'(Wrap), 32'd0);
    run_edges(4);
    check_eq("up_wrap_val", 32'(Value), 32'h00);
    check_eq("up_wrap_flag", 32'(Wrap), 32'd1);
    run_edges(1);
    check_eq("wrap_one_cycle", 32'(Wrap), 32'd0);

    // Switch to down between ticks: 00 -> 59 with wrap.
    In = 1'b1;
    run_edges(3);
    check_eq("dn_wrap_val", 32'(Value), 32'h59);
    check_eq("dn_wrap_flag", 32'(Wrap), 32'd1);
    repeat (48) run_edges(4);
    check_eq("dn_11", 32'(Value), 32'h11);
    run_edges(4);
    check_eq("dn_10", 32'(Value), 32'h10);
    run_edges(4);
    check_eq("dn_borrow_09", 32'(Value), 32'h09);
    check_eq("dn_borrow_nowrap", 32'(Wrap), 32'd0);

    // Direction wiggles between ticks: only In at the tick edge counts.
    run_edges(1); In = 1'b0;
    run_edges(1); In = 1'b1;
    run_edges(2);
    check_eq("toggle_dn_08", 32'(Value), 32'h08);
    run_edges(1); In = 1'b0;
    run_edges(3);
    check_eq("toggle_up_09", 32'(Value), 32'h09);
    run_edges(3);
    check_eq("no_double_step", 32'(Value), 32'h09);
    run_edges(1);
    check_eq("up_carry_10", 32'(Value), 32'h10);

    // Clear coinciding with a tick at 37.
    repeat (27) run_edges(4);
    check_eq("at_37", 32'(Value), 32'h37);
    run_edges(3);
    check_eq("tick_before_clr", 32'(Tick), 32'd1);
    Clear = 1'b1;
    run_edges(1);
    Clear = 1'b0;
    check_eq("clr_value", 32'(Value), 32'h00);
    check_eq("clr_wrap",  32'(Wrap),  32'd0);
    check_eq("clr_out_holds", 32'(Out), 32'({S3, S7}));
    run_edges(1);
    check_eq("clr_out_next", 32'(Out), 32'({HI_ZERO, S0}));
    run_edges(3);
    check_eq("after_clr_step", 32'(Value), 32'h01);

    // Enable low for 10 cycles freezes; next step 4 edges after re-enable.
    Enable = 1'b0;
    run_edges(10);
    check_eq("en_off_hold", 32'(Value), 32'h01);
    check_eq("en_off_tick", 32'(Tick),  32'd0);
    Enable = 1'b1;
    run_edges(3);
    check_eq("en_on_wait",  32'(Value), 32'h01);
    check_eq("en_on_tick",  32'(Tick),  32'd1);
    run_edges(1);
    check_eq("en_on_step",  32'(Value), 32'h02);

    // Display of 07: upper digit blank or zero depending on build.
    repeat (5) run_edges(4);
    check_eq("at_07", 32'(Value), 32'h07);
    run_edges(1);
    check_eq("out07_hi", 32'(Out[13:7]), 32'(HI_ZERO));
    check_eq("out07_lo", 32'(Out[6:0]),  32'(S7));

    // Asynchronous reset mid-divide at 42.
    run_edges(3);
    repeat (34) run_edges(4);
    check_eq("at_42", 32'(Value), 32'h42);
    run_edges(2);
    #2;
    Reset = 1'b1;
    #1;
    check_eq("arst_value", 32'(Value), 32'h00);
    check_eq("arst_wrap",  32'(Wrap),  32'd0);
    check_eq("arst_tick",  32'(Tick),  32'd0);
    check_eq("arst_out",   32'(Out),   32'({HI_ZERO, S0}));
    run_edges(2);
    Reset = 1'b0;
    check_eq("arst_release", 32'(Value), 32'h00);
    run_edges(3);
    check_eq("arst_tick_again", 32'(Tick), 32'd1);
    run_edges(1);
    check_eq("arst_first_step", 32'(Value), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
